// File: rtl/ysyx_22050019_wbu_pkg.sv
// Shared types and constants for the write-back unit and its LSU pending queue.
package ysyx_22050019_wbu_pkg;

   localparam int XLEN   = 64;  // datapath width
   localparam int NREG   = 32;  // architectural registers, x0 hardwired zero
   localparam int REG_W  = 5;   // register index width
   localparam int QDEPTH = 2;   // LSU write-pending queue depth (power of 2)
   localparam int NQUERY = 2;   // decode read ports searched for forwarding

   // One pending register write.
   typedef struct packed {
      logic [REG_W-1:0] waddr;
      logic [XLEN-1:0]  wdata;
   } wb_entry_t;

endpackage

// File: rtl/ysyx_22050019_wb_queue.sv
// Collapsing FIFO for LSU writes that lost commit arbitration to the EXU.
// Slot 0 is always the oldest entry and valid bits stay thermometer-coded, so
// killed entries are squeezed out immediately and never stall the commit port.
module ysyx_22050019_wb_queue
   import ysyx_22050019_wbu_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic                              push,
   input  wb_entry_t                         push_entry,
   input  logic                              pop,
   input  logic                              kill_en,
   input  logic [REG_W-1:0]                  kill_addr,
   output logic                              empty,
   output logic                              full,
   output wb_entry_t                         head,
   input  logic [NQUERY-1:0][REG_W-1:0]      search_addr,
   output logic [NQUERY-1:0]                 search_hit,
   output logic [NQUERY-1:0][XLEN-1:0]       search_data
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH + 1);

   logic [QDEPTH-1:0]            valid, valid_nxt;
   wb_entry_t [QDEPTH-1:0]       entries, entries_nxt;
   logic [CNT_W-1:0]             fill;

   assign empty = !valid[0];
   assign full  = valid[QDEPTH-1];
   assign head  = entries[0];

   // Next queue image: drop the popped head and killed entries, compact, then append.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      valid_nxt   = '0;
      entries_nxt = entries;
      fill        = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (valid[i] && !(pop && i == 0) &&
             !(kill_en && entries[i].waddr == kill_addr)) begin
            valid_nxt[fill[PTR_W-1:0]]   = 1'b1;
            entries_nxt[fill[PTR_W-1:0]] = entries[i];
            fill                         = fill + CNT_W'(1);
         end
      end
      if (push && fill < CNT_W'(QDEPTH)) begin
         valid_nxt[fill[PTR_W-1:0]]   = 1'b1;
         entries_nxt[fill[PTR_W-1:0]] = push_entry;
      end
   end

   // Queue state register; flush empties the queue but payload may stay stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= '0;
         // NOTE: the payload array is reset as well; it is tiny and this keeps X
         // out of the forwarding muxes even though valid already masks it.
         entries <= '0;
      end else if (flush) begin
         valid   <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         valid   <= valid_nxt;
         entries <= entries_nxt;
      end
   end

   // Forwarding search: walk oldest to youngest so the youngest match wins.
   always_comb begin
      search_hit  = '0;
      search_data = '0;
      for (int q = 0; q < NQUERY; q++) begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (valid[i] && entries[i].waddr == search_addr[q]) begin
               search_hit[q]  = 1'b1;
               search_data[q] = entries[i].wdata;
            end
         end
      end
   end

endmodule

// File: rtl/ysyx_22050019_wbu.sv
// Write-back unit: merges EXU and LSU writes into one registered regfile port,
// tracks long-latency destinations in a scoreboard, and answers decode RAW queries.
module ysyx_22050019_wbu
   import ysyx_22050019_wbu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             issue_long,
   input  logic [REG_W-1:0] issue_waddr,
   input  logic             exu_wen,
   input  logic [REG_W-1:0] exu_waddr,
   input  logic [XLEN-1:0]  exu_wdata,
   input  logic             lsu_wen,
   input  logic [REG_W-1:0] lsu_waddr,
   input  logic [XLEN-1:0]  lsu_wdata,
   output logic             lsu_ready,
   input  logic [REG_W-1:0] rs1_addr,
   input  logic [REG_W-1:0] rs2_addr,
   output logic             raw_stall,
   output logic             fwd1_hit,
   output logic [XLEN-1:0]  fwd1_data,
   output logic             fwd2_hit,
   output logic [XLEN-1:0]  fwd2_data,
   output logic             rf_wen,
   output logic [REG_W-1:0] rf_waddr,
   output logic [XLEN-1:0]  rf_wdata
);

   logic                         exu_ok;
   logic                         lsu_acc;
   logic                         lsu_kill;
   logic                         q_empty;
   logic                         q_full;
   logic                         q_pop;
   logic                         q_push;
   wb_entry_t                    q_head;
   logic [NQUERY-1:0][REG_W-1:0] rs_addr;
   logic [NQUERY-1:0]            q_hit;
   logic [NQUERY-1:0][XLEN-1:0]  q_data;
   logic [NQUERY-1:0]            fwd_hit;
   logic [NQUERY-1:0][XLEN-1:0]  fwd_data;
   logic [NREG-1:0]              busy;
   logic [NREG-1:0]              busy_nxt;

   // Readiness depends only on occupancy, never on a same-cycle pop.
   assign lsu_ready = !q_full;

   // Writes to x0 and anything presented during flush are ignored.
   assign exu_ok   = exu_wen && (exu_waddr != '0) && !flush;
   assign lsu_acc  = lsu_wen && lsu_ready && (lsu_waddr != '0) && !flush;
   // An older load to the register the EXU is writing now must never land.
   assign lsu_kill = exu_ok && (lsu_waddr == exu_waddr);

   assign q_pop  = !flush && !exu_ok && !q_empty;
   assign q_push = lsu_acc && !lsu_kill && (exu_ok || !q_empty);

   ysyx_22050019_wb_queue u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push        (q_push),
      .push_entry  ('{waddr: lsu_waddr, wdata: lsu_wdata}),
      .pop         (q_pop),
      .kill_en     (exu_ok),
      .kill_addr   (exu_waddr),
      .empty       (q_empty),
      .full        (q_full),
      .head        (q_head),
      .search_addr (rs_addr),
      .search_hit  (q_hit),
      .search_data (q_data)
   );

   // Commit arbiter: EXU first, then queued loads, then a bypassing load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (exu_ok) begin
         rf_wen   <= 1'b1;
         rf_waddr <= exu_waddr;
         rf_wdata <= exu_wdata;
      end else if (q_pop) begin
         rf_wen   <= 1'b1;
         rf_waddr <= q_head.waddr;
         rf_wdata <= q_head.wdata;
      end else if (lsu_acc) begin
         rf_wen   <= 1'b1;
         rf_waddr <= lsu_waddr;
         rf_wdata <= lsu_wdata;
      end else begin
         rf_wen   <= 1'b0;
      end
   end

   // Scoreboard update: completion clears, a new long op sets and wins, flush wipes.
   always_comb begin
      busy_nxt = busy;
      if (exu_ok) begin
         busy_nxt[exu_waddr] = 1'b0;
      end
      if (issue_long && issue_waddr != '0) begin
         busy_nxt[issue_waddr] = 1'b1;
      end
      if (flush) begin
         busy_nxt = '0;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign raw_stall = ((rs1_addr != '0) && busy[rs1_addr]) ||
                      ((rs2_addr != '0) && busy[rs2_addr]);

   assign rs_addr = {rs2_addr, rs1_addr};

   // Forward muxes, youngest producer first; x0 never forwards.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int q = 0; q < NQUERY; q++) begin
         if (rs_addr[q] != '0) begin
            if (exu_ok && exu_waddr == rs_addr[q]) begin
               fwd_hit[q]  = 1'b1;
               fwd_data[q] = exu_wdata;
            end else if (lsu_acc && lsu_waddr == rs_addr[q]) begin
               fwd_hit[q]  = 1'b1;
               fwd_data[q] = lsu_wdata;
            end else if (q_hit[q]) begin
               fwd_hit[q]  = 1'b1;
               fwd_data[q] = q_data[q];
            end else if (rf_wen && rf_waddr == rs_addr[q]) begin
               fwd_hit[q]  = 1'b1;
               fwd_data[q] = rf_wdata;
            end
         end
      end
   end

   assign fwd1_hit  = fwd_hit[0];
   assign fwd1_data = fwd_data[0];
   assign fwd2_hit  = fwd_hit[1];
   assign fwd2_data = fwd_data[1];

endmodule
